// File: rtl/elevator_scan_ctrl.sv
// SCAN elevator controller: serves a pending-request bitmap, keeping direction while work lies ahead.
// state | meaning: IDLE = car parked, door closed | MOVE = travelling one floor per TRAVEL_TICKS | DOOR = door open, timing DOOR_TICKS
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS   = 8,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 3,
    localparam int FLOOR_W     = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_i,
    input  logic                  door_hold_i,
    output logic [FLOOR_W-1:0]    cur_floor_o,
    output logic                  dir_o,
    output logic                  door_o,
    output logic [2:0]            state_out_o,
    output logic [NUM_FLOORS-1:0] pending_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_DOOR = 2'd2;

    localparam int TW = $clog2(TRAVEL_TICKS + 1);
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP         = FLOOR_W'(NUM_FLOORS - 1);

    logic [1:0]            state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic                  door_q, door_d;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [DW-1:0]         dcnt_q, dcnt_d;

    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] above_c, below_c, above_n, below_n;
    logic [FLOOR_W-1:0]    nf;
    logic                  next_up, arr_dir;

    function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
        return m;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [NUM_FLOORS-1:0] m;
        for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
        return m;
    endfunction

    always_comb begin
        // The step direction is clamped at the shaft ends regardless of dir_q.
        next_up = (floor_q == '0) ? 1'b1 : (floor_q == TOP) ? 1'b0 : dir_q;
        nf      = next_up ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        arr_dir = (nf == TOP) ? 1'b0 : (nf == '0) ? 1'b1 : next_up;
        above_c = pend_q & above_mask(floor_q);
        below_c = pend_q & below_mask(floor_q);
        above_n = pend_q & above_mask(nf);
        below_n = pend_q & below_mask(nf);

        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        door_d  = door_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        clr     = '0;

        case (state_q)
            ST_IDLE: begin
                door_d = 1'b0;
                if (pend_q[floor_q]) begin
                    state_d = ST_DOOR;
                    door_d  = 1'b1;
                    clr     = NUM_FLOORS'(1) << floor_q;
                    dcnt_d  = DOOR_LOAD;
                end else if (|above_c && |below_c) begin
                    state_d = ST_MOVE;
                    tcnt_d  = '0;
                end else if (|above_c) begin
                    state_d = ST_MOVE;
                    dir_d   = 1'b1;
                    tcnt_d  = '0;
                end else if (|below_c) begin
                    state_d = ST_MOVE;
                    dir_d   = 1'b0;
                    tcnt_d  = '0;
                end
            end
            ST_MOVE: begin
                door_d = 1'b0;
                if (tcnt_q == TRAVEL_LAST) begin
                    tcnt_d  = '0;
                    floor_d = nf;
                    if (pend_q[nf]) begin
                        state_d = ST_DOOR;
                        door_d  = 1'b1;
                        dir_d   = arr_dir;
                        clr     = NUM_FLOORS'(1) << nf;
                        dcnt_d  = DOOR_LOAD;
                    end else if (next_up ? |above_n : |below_n) begin
                        dir_d = next_up;
                    end else if (next_up ? |below_n : |above_n) begin
                        dir_d = ~next_up;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = arr_dir;
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            ST_DOOR: begin
                // Requests for the open floor are absorbed and keep the door open.
                clr = NUM_FLOORS'(1) << floor_q;
                if (door_hold_i || req_i[floor_q]) begin
                    dcnt_d = DOOR_LOAD;
                end else if (dcnt_q == '0) begin
                    door_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                door_d  = 1'b0;
            end
        endcase

        pend_d = (pend_q | req_i) & ~clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            floor_q <= '0;
            dir_q   <= 1'b1;
            door_q  <= 1'b0;
            pend_q  <= '0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            door_q  <= door_d;
            pend_q  <= pend_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign cur_floor_o = floor_q;
    assign dir_o       = dir_q;
    assign door_o      = door_q;
    assign state_out_o = {1'b0, state_q};
    assign pending_o   = pend_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: stop sequence scoreboard plus directed timing checks.
module tb_elevator_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_i;
    logic       door_hold_i;
    logic [2:0] cur_floor_o;
    logic       dir_o;
    logic       door_o;
    logic [2:0] state_out_o;
    logic [7:0] pending_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int e_last;

    typedef struct {
        int floor;
        int dir;
    } stop_t;
    stop_t exp_q[$];

    elevator_scan_ctrl #(
        .NUM_FLOORS  (8),
        .TRAVEL_TICKS(4),
        .DOOR_TICKS  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .door_hold_i(door_hold_i),
        .cur_floor_o(cur_floor_o),
        .dir_o      (dir_o),
        .door_o     (door_o),
        .state_out_o(state_out_o),
        .pending_o  (pending_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_stop(input int f, input int d);
        stop_t s;
        s.floor = f;
        s.dir   = d;
        exp_q.push_back(s);
    endtask

    // Called right after a falling edge; req is sampled on edge e_last.
    task automatic pulse(input logic [7:0] r);
        req_i  = r;
        e_last = cyc + 1;
        @(negedge clk);
        req_i  = 8'h00;
    endtask

    task automatic wait_edge(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(state_out_o == 3'd0 && pending_o == 8'h00 && door_o == 1'b0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 600) begin
            bad++;
            $display("FAIL idle_timeout: got state %0d pending %0d expected idle and empty", state_out_o, pending_o);
        end
    endtask

    task automatic wait_door_at(input int f);
        int n = 0;
        while (!(door_o == 1'b1 && int'(cur_floor_o) == f) && n < 600) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 600) begin
            bad++;
            $display("FAIL door_timeout: got floor %0d door %0d expected open at %0d", cur_floor_o, door_o, f);
        end
    endtask

    // Monitor: every door opening is a stop, compared against the queued expectation.
    initial begin
        logic door_prev = 1'b0;
        stop_t s;
        forever begin
            @(negedge clk);
            if (!reset && door_o && !door_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_stop_floor", int'(cur_floor_o), -1);
                end else begin
                    s = exp_q.pop_front();
                    check("stop_floor", int'(cur_floor_o), s.floor);
                    check("stop_dir", int'(dir_o), s.dir);
                end
            end
            door_prev = door_o;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        req_i       = 8'h00;
        door_hold_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_floor", int'(cur_floor_o), 0);
        check("rst_dir", int'(dir_o), 1);
        check("rst_state", int'(state_out_o), 0);
        reset = 1'b0;

        // Single request for floor 3 from floor 0
        push_stop(3, 1);
        pulse(8'h08);
        check("t2_pend_e0", int'(pending_o), 8'h08);
        check("t2_state_e0", int'(state_out_o), 0);
        wait_edge(e_last + 1);
        check("t2_move_e1", int'(state_out_o), 1);
        wait_edge(e_last + 4);
        check("t2_floor_e4", int'(cur_floor_o), 0);
        wait_edge(e_last + 5);
        check("t2_floor_e5", int'(cur_floor_o), 1);
        wait_edge(e_last + 9);
        check("t2_floor_e9", int'(cur_floor_o), 2);
        check("t2_door_e9", int'(door_o), 0);
        wait_edge(e_last + 13);
        check("t2_floor_e13", int'(cur_floor_o), 3);
        check("t2_door_e13", int'(door_o), 1);
        check("t2_pend_e13", int'(pending_o), 0);
        check("t2_state_e13", int'(state_out_o), 2);
        wait_edge(e_last + 15);
        check("t2_door_e15", int'(door_o), 1);
        wait_edge(e_last + 16);
        check("t2_door_e16", int'(door_o), 0);
        check("t2_state_e16", int'(state_out_o), 0);

        // Asynchronous reset in the middle of a move toward floor 7
        pulse(8'h80);
        wait_edge(e_last + 7);
        check("t1_floor_pre", int'(cur_floor_o), 4);
        check("t1_state_pre", int'(state_out_o), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t1_floor", int'(cur_floor_o), 0);
        check("t1_dir", int'(dir_o), 1);
        check("t1_door", int'(door_o), 0);
        check("t1_pend", int'(pending_o), 0);
        check("t1_state", int'(state_out_o), 0);
        @(negedge clk);
        reset = 1'b0;

        // SCAN order: 2, 5, 6 upward, then reverse to 1
        push_stop(2, 1);
        push_stop(5, 1);
        push_stop(6, 1);
        push_stop(1, 0);
        pulse(8'h24);
        wait_door_at(2);
        pulse(8'h02);
        check("t3_pend_behind", int'(pending_o[1]), 1);
        pulse(8'h40);
        wait_idle();
        check("t3_end_floor", int'(cur_floor_o), 1);

        // Current-floor request at an idle car parked on floor 4
        push_stop(4, 1);
        pulse(8'h10);
        wait_idle();
        push_stop(4, 1);
        pulse(8'h10);
        wait_edge(e_last + 1);
        check("t4_state_e1", int'(state_out_o), 2);
        check("t4_door_e1", int'(door_o), 1);
        check("t4_floor_e1", int'(cur_floor_o), 4);
        check("t4_pend_e1", int'(pending_o), 0);
        wait_edge(e_last + 3);
        check("t4_door_e3", int'(door_o), 1);
        wait_edge(e_last + 4);
        check("t4_door_e4", int'(door_o), 0);
        check("t4_state_e4", int'(state_out_o), 0);
        check("t4_floor_e4", int'(cur_floor_o), 4);

        // Door hold for 10 edges, then 3 more open cycles
        push_stop(4, 1);
        pulse(8'h10);
        wait_edge(e_last + 1);
        door_hold_i = 1'b1;
        wait_edge(e_last + 11);
        door_hold_i = 1'b0;
        check("t5_door_hold_end", int'(door_o), 1);
        wait_edge(e_last + 13);
        check("t5_door_e13", int'(door_o), 1);
        wait_edge(e_last + 14);
        check("t5_door_e14", int'(door_o), 0);
        check("t5_state_e14", int'(state_out_o), 0);

        // Same-floor request while open reloads the door timer
        push_stop(4, 1);
        pulse(8'h10);
        wait_edge(e_last + 1);
        req_i = 8'h10;
        wait_edge(e_last + 2);
        req_i = 8'h00;
        check("t5_req_absorbed", int'(pending_o), 0);
        wait_edge(e_last + 4);
        check("t5_req_door_e4", int'(door_o), 1);
        wait_edge(e_last + 5);
        check("t5_req_door_e5", int'(door_o), 0);

        // Top boundary: park at 7, then request every floor
        push_stop(7, 0);
        pulse(8'h80);
        wait_idle();
        check("t6_at_top", int'(cur_floor_o), 7);
        push_stop(7, 0);
        for (int f = 6; f >= 1; f--) push_stop(f, 0);
        push_stop(0, 1);
        pulse(8'hFF);
        check("t6_pend_all", int'(pending_o), 8'hFF);
        wait_idle();
        check("t6_end_floor", int'(cur_floor_o), 0);

        // Request held across its own clearing edge: clear wins, single stop
        push_stop(0, 1);
        req_i  = 8'h01;
        e_last = cyc + 1;
        wait_edge(e_last + 1);
        req_i  = 8'h00;
        check("t6_clear_wins", int'(pending_o), 0);
        check("t6_clear_state", int'(state_out_o), 2);
        wait_idle();
        repeat (10) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
